// File: rtl/wb_get_block.sv
// wb_get_block: pipelined Wishbone-style burst-read sequencer.
// Each read_i pulse fetches one block of BSIZE words; done_o pulses when it completes or aborts.
module wb_get_block #(
  parameter int BSIZE = 24,
  parameter int BBITS = 5,
  parameter int BSB   = BBITS - 1,
  parameter int DELAY = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic         cyc_o,
  output logic         stb_o,
  output logic         we_o,
  output logic         bst_o,
  input  logic         ack_i,
  input  logic         wat_i,
  input  logic         err_i,
  output logic [BSB:0] adr_o,
  input  logic         read_i,
  output logic         done_o
);

  localparam int AW = BSB + 1;
  localparam int CW = BBITS + 1;
  localparam logic [BSB:0]   ADR_LAST = AW'(BSIZE - 1);
  localparam logic [BBITS:0] CNT_LAST = CW'(BSIZE - 1);

  // Reject block sizes the address field cannot hold; DELAY only affects simulation timing.
  if (BSIZE < 1 || BSIZE > (1 << BBITS) || DELAY < 0) begin : g_bad_params
    $error("wb_get_block: illegal parameter combination");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t         state_q, state_d;
  logic           stb_q, stb_d;
  logic [BSB:0]   adr_q, adr_d;
  logic [BBITS:0] cnt_q, cnt_d;
  logic           done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_i) begin
          state_d = BUSY;
          stb_d   = 1'b1;
          adr_d   = '0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (err_i) begin
          state_d = IDLE;
          stb_d   = 1'b0;
          adr_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          // The address parks on the last word so it never leaves the block.
          if (stb_q && !wat_i) begin
            if (adr_q == ADR_LAST) begin
              stb_d = 1'b0;
            end else begin
              adr_d = adr_q + 1'b1;
            end
          end
          if (ack_i) begin
            if (cnt_q == CNT_LAST) begin
              state_d = IDLE;
              stb_d   = 1'b0;
              adr_d   = '0;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cyc_o  = (state_q == BUSY);
  assign stb_o  = stb_q;
  assign we_o   = 1'b0;
  assign bst_o  = stb_q && (adr_q != ADR_LAST);
  assign adr_o  = adr_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_wb_get_block.sv
// Directed bench for wb_get_block: a 24-word instance with a latency-1 slave model,
// plus a single-word instance for the BSIZE=1 back-to-back case.
module tb_wb_get_block;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic cyc, stb, we, bst, ack = 1'b0, wat = 1'b0, err = 1'b0, read = 1'b0, done;
  logic [4:0] adr;
  logic cyc1, stb1, we1, bst1, ack1 = 1'b0, wat1 = 1'b0, err1 = 1'b0, read1 = 1'b0, done1;
  logic [4:0] adr1;

  int checks = 0;
  int errors = 0;

  int r_acc, r_ack, r_done_n, r_ndone, r_adr5, r_post_cyc;
  logic r_seq_ok, r_bst_ok, r_done_cyc;
  logic [4:0] r_done_adr;

  always #5 clk = ~clk;

  wb_get_block #(.BSIZE(24), .BBITS(5)) dut (
    .clk_i(clk), .rst_i(rst_n), .cyc_o(cyc), .stb_o(stb), .we_o(we), .bst_o(bst),
    .ack_i(ack), .wat_i(wat), .err_i(err), .adr_o(adr), .read_i(read), .done_o(done)
  );

  wb_get_block #(.BSIZE(1), .BBITS(5)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .cyc_o(cyc1), .stb_o(stb1), .we_o(we1), .bst_o(bst1),
    .ack_i(ack1), .wat_i(wat1), .err_i(err1), .adr_o(adr1), .read_i(read1), .done_o(done1)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    @(posedge clk); #1;
    read = 0; ack = 0; wat = 0; err = 0;
    read1 = 0; ack1 = 0; wat1 = 0; err1 = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // Runs one block on the 24-word DUT; n=0 is the read_i cycle. Slave acks one cycle after accept.
  task automatic run_block(input int wait_adr, input int wait_len, input int err_ack, input int reread_n);
    bit acc_prev;
    bit err_sent;
    int waits;
    int stop_n;
    acc_prev = 0; err_sent = 0; waits = wait_len; stop_n = 80;
    r_acc = 0; r_ack = 0; r_done_n = -1; r_ndone = 0; r_adr5 = 0; r_post_cyc = 0;
    r_seq_ok = 1; r_bst_ok = 1; r_done_adr = 5'h1f; r_done_cyc = 1;
    for (int n = 0; n < stop_n; n++) begin
      if (done) begin
        r_ndone++;
        if (r_done_n < 0) begin
          r_done_n = n; r_done_adr = adr; r_done_cyc = cyc; stop_n = n + 4;
        end
      end else if (r_done_n >= 0 && cyc) begin
        r_post_cyc++;
      end
      if (stb && adr == 5'd5) r_adr5++;
      read = (n == 0) || (n == reread_n);
      ack = acc_prev && !err_sent;
      err = 0;
      if (ack) begin
        r_ack++;
        if (r_ack == err_ack) begin err = 1; err_sent = 1; end
      end
      wat = 0;
      if (stb && adr == wait_adr[4:0] && waits > 0) begin wat = 1; waits--; end
      acc_prev = stb && !wat;
      if (acc_prev) begin
        if (adr != r_acc[4:0]) r_seq_ok = 0;
        if (bst != (r_acc < 23)) r_bst_ok = 0;
        r_acc++;
      end
      @(posedge clk); #1;
    end
    read = 0; ack = 0; err = 0; wat = 0;
    $display("block: accepts=%0d acks=%0d done_at=%0d dones=%0d", r_acc, r_ack, r_done_n, r_ndone);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (cyc !== 0) begin errors++; $display("FAIL reset_cyc: got %0b expected 0", cyc); end
    checks++; if (stb !== 0 || bst !== 0) begin errors++; $display("FAIL reset_stb_bst: got %0b%0b expected 00", stb, bst); end
    checks++; if (adr !== 0) begin errors++; $display("FAIL reset_adr: got %0d expected 0", adr); end
    checks++; if (done !== 0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (cyc1 !== 0 || stb1 !== 0 || done1 !== 0) begin errors++; $display("FAIL reset_dut1: got %0b%0b%0b expected 000", cyc1, stb1, done1); end
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cyc !== 0) begin errors++; $display("FAIL reset_idle_cyc: got %0b expected 0", cyc); end
    $display("reset: cyc=%0b stb=%0b adr=%0d done=%0b", cyc, stb, adr, done);
  endtask

  task automatic test_basic();
    do_reset();
    checks++; if (we !== 0) begin errors++; $display("FAIL basic_we: got %0b expected 0", we); end
    run_block(31, 0, 0, -1);
    checks++; if (r_acc !== 24) begin errors++; $display("FAIL basic_accepts: got %0d expected 24", r_acc); end
    checks++; if (r_ack !== 24) begin errors++; $display("FAIL basic_acks: got %0d expected 24", r_ack); end
    checks++; if (r_seq_ok !== 1) begin errors++; $display("FAIL basic_adr_seq: got %0b expected 1", r_seq_ok); end
    checks++; if (r_bst_ok !== 1) begin errors++; $display("FAIL basic_bst: got %0b expected 1", r_bst_ok); end
    checks++; if (r_done_n !== 26) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 26", r_done_n); end
    checks++; if (r_ndone !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", r_ndone); end
    checks++; if (r_done_cyc !== 0 || r_done_adr !== 0) begin errors++; $display("FAIL basic_done_bus: got cyc=%0b adr=%0d expected cyc=0 adr=0", r_done_cyc, r_done_adr); end
    checks++; if (r_post_cyc !== 0) begin errors++; $display("FAIL basic_post_cyc: got %0d expected 0", r_post_cyc); end
  endtask

  task automatic test_wait();
    do_reset();
    run_block(5, 3, 0, -1);
    checks++; if (r_adr5 !== 4) begin errors++; $display("FAIL wait_adr5_cycles: got %0d expected 4", r_adr5); end
    checks++; if (r_ack !== 24) begin errors++; $display("FAIL wait_acks: got %0d expected 24", r_ack); end
    checks++; if (r_seq_ok !== 1) begin errors++; $display("FAIL wait_adr_seq: got %0b expected 1", r_seq_ok); end
    checks++; if (r_done_n !== 29) begin errors++; $display("FAIL wait_done_cycle: got %0d expected 29", r_done_n); end
    checks++; if (r_ndone !== 1) begin errors++; $display("FAIL wait_done_count: got %0d expected 1", r_ndone); end
  endtask

  task automatic test_error();
    do_reset();
    run_block(31, 0, 10, -1);
    checks++; if (r_done_n !== 12) begin errors++; $display("FAIL err_done_cycle: got %0d expected 12", r_done_n); end
    checks++; if (r_done_cyc !== 0 || r_done_adr !== 0) begin errors++; $display("FAIL err_done_bus: got cyc=%0b adr=%0d expected cyc=0 adr=0", r_done_cyc, r_done_adr); end
    checks++; if (r_ndone !== 1) begin errors++; $display("FAIL err_done_count: got %0d expected 1", r_ndone); end
    checks++; if (r_post_cyc !== 0) begin errors++; $display("FAIL err_post_cyc: got %0d expected 0", r_post_cyc); end
    run_block(31, 0, 0, -1);
    checks++; if (r_seq_ok !== 1 || r_acc !== 24) begin errors++; $display("FAIL err_restart_seq: got ok=%0b accepts=%0d expected ok=1 accepts=24", r_seq_ok, r_acc); end
    checks++; if (r_done_n !== 26) begin errors++; $display("FAIL err_restart_done: got %0d expected 26", r_done_n); end
  endtask

  task automatic test_reread();
    do_reset();
    ack = 1;
    repeat (2) @(posedge clk);
    #1;
    ack = 0;
    run_block(31, 0, 0, 8);
    checks++; if (r_done_n !== 26) begin errors++; $display("FAIL reread_done_cycle: got %0d expected 26", r_done_n); end
    checks++; if (r_ndone !== 1) begin errors++; $display("FAIL reread_done_count: got %0d expected 1", r_ndone); end
    checks++; if (r_acc !== 24 || r_seq_ok !== 1) begin errors++; $display("FAIL reread_accepts: got %0d ok=%0b expected 24 ok=1", r_acc, r_seq_ok); end
    checks++; if (r_post_cyc !== 0) begin errors++; $display("FAIL reread_post_cyc: got %0d expected 0", r_post_cyc); end
  endtask

  task automatic test_async_reset();
    int ndone;
    int ncyc;
    do_reset();
    read = 1;
    @(posedge clk); #1;
    read = 0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if (adr !== 9 || cyc !== 1) begin errors++; $display("FAIL arst_pre_adr: got adr=%0d cyc=%0b expected adr=9 cyc=1", adr, cyc); end
    #3 rst_n = 0;
    #1;
    checks++; if (cyc !== 0 || stb !== 0 || bst !== 0) begin errors++; $display("FAIL arst_bus_now: got %0b%0b%0b expected 000", cyc, stb, bst); end
    checks++; if (adr !== 0) begin errors++; $display("FAIL arst_adr_now: got %0d expected 0", adr); end
    #2 rst_n = 1;
    ndone = 0; ncyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (cyc) ncyc++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL arst_no_done: got %0d expected 0", ndone); end
    checks++; if (ncyc !== 0) begin errors++; $display("FAIL arst_no_cyc: got %0d expected 0", ncyc); end
    $display("async reset: dones=%0d busy_cycles=%0d", ndone, ncyc);
  endtask

  task automatic test_back_to_back();
    do_reset();
    read1 = 1;
    @(posedge clk); #1;
    read1 = 0;
    checks++; if (cyc1 !== 1 || stb1 !== 1 || adr1 !== 0 || bst1 !== 0) begin errors++; $display("FAIL b1_first_strobe: got cyc=%0b stb=%0b adr=%0d bst=%0b expected 1 1 0 0", cyc1, stb1, adr1, bst1); end
    @(posedge clk); #1;
    checks++; if (stb1 !== 0) begin errors++; $display("FAIL b1_single_strobe: got %0b expected 0", stb1); end
    ack1 = 1;
    @(posedge clk); #1;
    ack1 = 0;
    checks++; if (done1 !== 1 || cyc1 !== 0) begin errors++; $display("FAIL b1_done: got done=%0b cyc=%0b expected 1 0", done1, cyc1); end
    read1 = 1;
    @(posedge clk); #1;
    read1 = 0;
    checks++; if (cyc1 !== 1 || stb1 !== 1 || adr1 !== 0 || done1 !== 0) begin errors++; $display("FAIL b1_restart: got cyc=%0b stb=%0b adr=%0d done=%0b expected 1 1 0 0", cyc1, stb1, adr1, done1); end
    @(posedge clk); #1;
    ack1 = 1;
    @(posedge clk); #1;
    ack1 = 0;
    checks++; if (done1 !== 1) begin errors++; $display("FAIL b1_second_done: got %0b expected 1", done1); end
    @(posedge clk); #1;
    checks++; if (done1 !== 0) begin errors++; $display("FAIL b1_done_width: got %0b expected 0", done1); end
    $display("bsize1: two blocks back to back, last done=%0b", done1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_error();
    test_reread();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
